// File: rtl/cu_rr_selector.sv
// Takes one workgroup allocation request at a time and runs the CAM search for it.
// Picks one fitting CU round-robin and returns its id and segment start over valid/ready.
module cu_rr_selector #(
  parameter int NUM_CU       = 8,
  parameter int CU_ID_WIDTH  = 3,
  parameter int RES_ID_WIDTH = 10,
  parameter int WG_ID_WIDTH  = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [RES_ID_WIDTH:0]          req_size_i,
  input  logic [WG_ID_WIDTH-1:0]         req_wg_id_i,
  output logic                           search_en_o,
  output logic [RES_ID_WIDTH:0]          search_size_o,
  input  logic [NUM_CU-1:0]              search_out_i,
  input  logic [NUM_CU*RES_ID_WIDTH-1:0] search_start_i,
  output logic                           alloc_valid_o,
  input  logic                           alloc_ready_i,
  output logic                           alloc_found_o,
  output logic [CU_ID_WIDTH-1:0]         alloc_cu_id_o,
  output logic [RES_ID_WIDTH-1:0]        alloc_start_o,
  output logic [RES_ID_WIDTH:0]          alloc_size_o,
  output logic [WG_ID_WIDTH-1:0]         alloc_wg_id_o
);

  typedef enum logic [1:0] {IDLE, SRCH, EVAL, OUT} state_e;

  state_e                   state_q, state_d;
  logic [RES_ID_WIDTH:0]    size_q;
  logic [WG_ID_WIDTH-1:0]   wg_q;
  logic [CU_ID_WIDTH-1:0]   rr_q, rr_d;
  logic                     found_q;
  logic [CU_ID_WIDTH-1:0]   cu_q;
  logic [RES_ID_WIDTH-1:0]  start_q;

  logic [NUM_CU-1:0][RES_ID_WIDTH-1:0] starts;
  logic                     hit;
  logic [CU_ID_WIDTH-1:0]   hit_idx;

  assign starts = search_start_i;

  // Scan from the farthest offset back to rr_q so the nearest set bit wins.
  always_comb begin
    int idx;
    idx     = 0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int j = NUM_CU - 1; j >= 0; j--) begin
      idx = (int'(rr_q) + j) % NUM_CU;
      if (search_out_i[idx]) begin
        hit     = 1'b1;
        hit_idx = CU_ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (hit) rr_d = (hit_idx == CU_ID_WIDTH'(NUM_CU - 1)) ? '0 : hit_idx + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    search_en_o   = 1'b0;
    alloc_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = SRCH;
      end
      SRCH: begin
        search_en_o = 1'b1;
        state_d     = EVAL;
      end
      EVAL: state_d = OUT;
      OUT: begin
        alloc_valid_o = 1'b1;
        if (alloc_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      wg_q    <= '0;
      rr_q    <= '0;
      found_q <= 1'b0;
      cu_q    <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        size_q <= req_size_i;
        wg_q   <= req_wg_id_i;
      end
      // The CAM result for the SRCH-cycle enable is only visible in EVAL.
      if (state_q == EVAL) begin
        found_q <= hit;
        cu_q    <= hit ? hit_idx : '0;
        start_q <= hit ? starts[hit_idx] : '0;
        rr_q    <= rr_d;
      end
    end
  end

  assign search_size_o = size_q;
  assign alloc_found_o = found_q;
  assign alloc_cu_id_o = cu_q;
  assign alloc_start_o = start_q;
  assign alloc_size_o  = size_q;
  assign alloc_wg_id_o = wg_q;

endmodule

// File: tb/tb_cu_rr_selector.sv
// Directed bench for cu_rr_selector: a stub CAM drives a fixed bitmap and start table,
// and each request is walked state by state against hand-computed results.
module tb_cu_rr_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_size;
  logic [14:0] req_wg;
  logic        search_en;
  logic [10:0] search_size;
  logic [7:0]  cam_out;
  logic [79:0] cam_start;
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_found;
  logic [2:0]  alloc_cu;
  logic [9:0]  alloc_start;
  logic [10:0] alloc_size;
  logic [14:0] alloc_wg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cu_rr_selector dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_size_i(req_size), .req_wg_id_i(req_wg),
    .search_en_o(search_en), .search_size_o(search_size),
    .search_out_i(cam_out), .search_start_i(cam_start),
    .alloc_valid_o(alloc_valid), .alloc_ready_i(alloc_ready),
    .alloc_found_o(alloc_found), .alloc_cu_id_o(alloc_cu),
    .alloc_start_o(alloc_start), .alloc_size_o(alloc_size),
    .alloc_wg_id_o(alloc_wg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT in IDLE; leaves at a negedge back in IDLE.
  task automatic run_req(input logic [10:0] sz, input logic [14:0] wg, input logic [7:0] bm,
                         input logic ef, input logic [2:0] ecu, input logic [9:0] est,
                         input int hold);
    cam_out     = bm;
    req_size    = sz;
    req_wg      = wg;
    req_valid   = 1'b1;
    alloc_ready = (hold == 0);
    chk("idle_ready", req_ready, 1);
    chk("idle_en", search_en, 0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("srch_en", search_en, 1);
    chk("srch_size", search_size, sz);
    chk("srch_ready", req_ready, 0);
    chk("srch_valid", alloc_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("eval_en", search_en, 0);
    chk("eval_valid", alloc_valid, 0);
    chk("eval_ready", req_ready, 0);
    @(posedge clk); @(negedge clk);
    chk("out_valid", alloc_valid, 1);
    chk("out_found", alloc_found, ef);
    chk("out_cu", alloc_cu, ecu);
    chk("out_start", alloc_start, est);
    chk("out_size", alloc_size, sz);
    chk("out_wg", alloc_wg, wg);
    chk("out_ready", req_ready, 0);
    for (int c = 0; c < hold; c++) begin
      req_valid = 1'b1;
      req_size  = ~sz;
      cam_out   = ~bm;
      @(posedge clk); @(negedge clk);
      chk("hold_valid", alloc_valid, 1);
      chk("hold_cu", alloc_cu, ecu);
      chk("hold_start", alloc_start, est);
      chk("hold_size", alloc_size, sz);
      chk("hold_ready", req_ready, 0);
      chk("hold_en", search_en, 0);
    end
    req_valid   = 1'b0;
    cam_out     = bm;
    alloc_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("done_valid", alloc_valid, 0);
    chk("done_ready", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_size = '0; req_wg = '0;
    cam_out = '0; alloc_ready = 1'b0;
    for (int i = 0; i < 8; i++) cam_start[i*10 +: 10] = (i == 0) ? 10'd7 : 10'(i * 20);
    @(negedge clk); @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", alloc_valid, 0);
    chk("rst_en", search_en, 0);
    chk("rst_ssize", search_size, 0);
    chk("rst_found", alloc_found, 0);
    chk("rst_wg", alloc_wg, 0);
    rst = 1'b0;

    // Move rr to 4, then reset while the result is waiting in OUT.
    cam_out = 8'h08; req_size = 11'd9; req_wg = 15'h1234; req_valid = 1'b1;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_cu", alloc_cu, 3);
    chk("pre_rst_start", alloc_start, 60);
    chk("pre_rst_valid", alloc_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", alloc_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_en", search_en, 0);
    chk("mid_rst_cu", alloc_cu, 0);
    @(negedge clk); rst = 1'b0;

    // rr back at 0 -> CU2 rather than CU5.
    run_req(11'd5, 15'h0055, 8'b0010_0100, 1, 3'd2, 10'd40, 0);
    run_req(11'd6, 15'h0101, 8'b0010_0100, 1, 3'd5, 10'd100, 0);
    run_req(11'd1, 15'h0202, 8'b0000_0001, 1, 3'd0, 10'd7, 0);
    run_req(11'd2, 15'h0303, 8'b0000_0000, 0, 3'd0, 10'd0, 0);
    // rr must still be 1 after the miss, so CU1 beats CU0.
    run_req(11'd3, 15'h7fff, 8'b0000_0011, 1, 3'd1, 10'd20, 5);
    // Back-to-back with ready held high.
    run_req(11'd0, 15'h0404, 8'hff, 1, 3'd2, 10'd40, 0);
    run_req(11'd2047, 15'h0505, 8'h80, 1, 3'd7, 10'd140, 0);
    run_req(11'd4, 15'h0606, 8'h81, 1, 3'd0, 10'd7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
